// File: rtl/seq_detect_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param_pkg
// Description : Shared types and default sizing for the parametrised serial
//               bit-pattern detector.
// Contents    : state_t  - detector state encoding (IDLE / RUN)
//               DEF_MAX_LEN, DEF_CNT_W - default parameter values
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_param_pkg;

  // Detector state: IDLE holds match low, RUN performs detection.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

endpackage : seq_detect_param_pkg
`default_nettype wire

// File: rtl/seq_detect_param_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_counter
// Description : Saturating match counter with synchronous clear. A clear
//               beats a same-cycle increment; the count holds at all-ones.
// Ports       : clk_i    - rising-edge clock
//               rst_ni   - asynchronous active-low reset
//               clr_i    - synchronous clear
//               inc_i    - increment request (one match)
//               count_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : seq_match_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parametrised serial bit-pattern detector. Matches a runtime
//               loaded pattern of 1..MAX_LEN bits against a qualified serial
//               stream, with overlapping or non-overlapping detection, a
//               Mealy match, a registered match and a saturating counter.
// Ports       : clk_i          - rising-edge clock
//               rst_ni         - asynchronous active-low reset
//               cfg_load_i     - latch pattern/length/overlap this cycle
//               cfg_pattern_i  - pattern, bit len-1 is received first
//               cfg_len_i      - pattern length, legal 1..MAX_LEN
//               cfg_overlap_i  - 1 = overlapping detection
//               cfg_err_o      - one-cycle pulse on an illegal cfg_len_i
//               in_valid_i     - qualifies in_bit_i
//               in_bit_i       - serial data
//               match_o        - combinational match on the completing bit
//               match_q_o      - match_o delayed by one clock
//               clr_count_i    - synchronous clear of match_count_o
//               match_count_o  - saturating number of matches
//               armed_o        - legal configuration loaded (state RUN)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  output logic               cfg_err_o,
  input  logic               in_valid_i,
  input  logic               in_bit_i,
  output logic               match_o,
  output logic               match_q_o,
  input  logic               clr_count_i,
  output logic [CNT_W-1:0]   match_count_o,
  output logic               armed_o
);

  // --------------------------------------------------------------------------
  // State and configuration registers
  // --------------------------------------------------------------------------
  state_t               state_q,   state_d;
  logic [MAX_LEN-2:0]   hist_q,    hist_d;
  logic [LEN_W-1:0]     fill_q,    fill_d;
  logic [MAX_LEN-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]     len_q,     len_d;
  logic                 overlap_q, overlap_d;
  logic                 match_q_q;
  logic                 cfg_err_q, cfg_err_d;

  // --------------------------------------------------------------------------
  // Match datapath (depends only on registered config, never on cfg_*)
  // --------------------------------------------------------------------------
  logic [MAX_LEN-1:0] w_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_hit;
  logic               w_match;
  logic               w_cfg_legal;

  // Window of the newest MAX_LEN bits including the one on the input now.
  assign w_shift = {hist_q, in_bit_i};

  // Only the low len_q bits of the window take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (len_q > LEN_W'(gi));
  end

  // fill >= len-1, written as fill+1 >= len to avoid underflow on len=0.
  assign w_fill_ok = (({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q});
  assign w_hit     = (((w_shift ^ pattern_q) & w_mask) == '0);
  assign w_match   = (state_q == ST_RUN) && in_valid_i && w_fill_ok && w_hit;

  assign w_cfg_legal = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    cfg_err_d = 1'b0;

    // History shifts in every state, including IDLE.
    if (in_valid_i) begin
      hist_d = w_shift[MAX_LEN-2:0];
      if (w_match && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    // A load always restarts the fill count, overriding the updates above,
    // so bits seen before the load can never complete a match.
    if (cfg_load_i) begin
      fill_d = '0;
      if (w_cfg_legal) begin
        state_d   = ST_RUN;
        pattern_d = cfg_pattern_i;
        len_d     = cfg_len_i;
        overlap_d = cfg_overlap_i;
      end else begin
        state_d   = ST_IDLE;
        pattern_d = '0;
        len_d     = '0;
        overlap_d = 1'b0;
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      match_q_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      match_q_q <= w_match;
      cfg_err_q <= cfg_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Match counter
  // --------------------------------------------------------------------------
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_count_i),
    .inc_i   (w_match),
    .count_o (match_count_o)
  );

  assign match_o   = w_match;
  assign match_q_o = match_q_q;
  assign cfg_err_o = cfg_err_q;
  assign armed_o   = (state_q == ST_RUN);

endmodule : seq_detect_param
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the configurable successor to the fixed four-bit Mealy detector. It matches a runtime-loaded pattern of 1..MAX_LEN bits against a qualified serial bit stream. Overlapping or non-overlapping detection is selectable. It provides both a Mealy (same-cycle) and a registered (Moore-style) match output, plus a saturating match counter. It sits directly on a serial data path as a framing/sync-word detector.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived; not to be overridden).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_load  in  1  latch pattern, length and overlap mode this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit expected, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when cfg_load carries an illegal cfg_len.
- in_valid  in  1  in_bit qualifier; bits are consumed only when it is high.
- in_bit  in  1  serial data.
- match  out  1  Mealy output: high in the cycle whose valid bit completes the pattern.
- match_q  out  1  match registered one cycle later.
- clr_count  in  1  synchronous clear of match_count.
- match_count  out  CNT_W  number of matches, saturating at all-ones.
- armed  out  1  high when a legal configuration is loaded (state RUN).

## Operation
- Reset state:
  - State is IDLE.
  - hist=0, fill=0, pattern=0, len=0, overlap=0.
  - match_q=0, match_count=0, cfg_err=0, armed=0.
- IDLE: match is held at 0. Input bits still shift into hist.
- RUN: detection is active.
- Transitions:
  - Any state → RUN on cfg_load with 1≤cfg_len≤MAX_LEN.
  - Any state → IDLE on cfg_load with cfg_len=0 or cfg_len>MAX_LEN. This also pulses cfg_err for one cycle and clears the stored configuration.
- Configuration side effect: every cfg_load (legal or illegal) clears fill. Bits received before the load never contribute to a match.
- History register: on in_valid, hist ← {hist[MAX_LEN-2:0], in_bit} and fill ← min(fill+1, MAX_LEN).
- Match condition (combinational, RUN only): in_valid && fill ≥ len-1 && {hist[len-2:0], in_bit} == pattern[len-1:0]. For len=1 the condition reduces to in_bit == pattern[0].
- After a match:
  - overlap=1: fill advances normally.
  - overlap=0: fill is forced to 0, so the next match needs len fresh bits.
- Gaps: in_valid=0 freezes hist, fill and match. Gaps of any length are transparent to detection.
- Counter priority:
  - clr_count wins over a same-cycle match; the count becomes 0 and that match is not counted.
  - Otherwise each match increments the count until it reaches 2^CNT_W-1, then it holds.
- cfg_load and in_valid in the same cycle:
  - The new configuration takes effect next cycle.
  - The current bit is evaluated against the old configuration.
  - fill is still cleared; the clear overrides both the increment and the non-overlap reset.

## Timing
- match: zero-latency combinational from in_bit/in_valid and registered state. No combinational path from cfg_* to match.
- match_q: match delayed exactly one clk.
- match_count: updates on the clk edge that ends the match cycle.
- cfg_err: asserts on the edge after an illegal cfg_load and lasts one cycle.
- armed: asserts on the edge after a legal cfg_load.
- Asynchronous reset mid-stream:
  - All registered outputs go to their reset values immediately.
  - match drops to 0 because the state is IDLE.
  - No match is possible until a new cfg_load followed by len valid bits.

## Structure
- Shared package: state encoding (IDLE, RUN) and the default MAX_LEN and CNT_W constants.
- Natural sub-module: seq_match_counter, the saturating counter with clear.
- Everything else stays in the top module.

## Test plan
- Overlapping match: load pattern 4'b1101, len=4, overlap=1. Stream 1,1,0,1,1,0,1 → match on bits 4 and 7; match_q on the following cycles; match_count=2.
- Non-overlapping match: same stream with overlap=0 → match on bit 4 only; match_count=1.
- Gaps: pattern 1101 with in_valid low for 3 cycles between every bit → one match on the last bit. match stays 0 during the gap cycles.
- Illegal configuration: cfg_len=0, then cfg_len=MAX_LEN+1 → cfg_err pulses each time and armed=0. The stream 1101 gives no match.
- Full length and saturation: MAX_LEN=8 with 8'hA5, CNT_W=2. Stream A5 repeated 5 times with overlap=0 → match_count saturates at 3. clr_count asserted in a match cycle → count 0.
- Reset during stream: rst_n low after bits 1,1,0, then release and reload 1101. Feeding bit 1 gives no match; a full fresh 1101 matches.
